receiver_credit_fifo: RTL

RECEIVER_CREDIT_FIFO -- requirements
Module: receiver_credit_fifo

---
 rtl/receiver_credit_fifo_if.sv | 60 ++++++
 rtl/receiver_credit_fifo.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/receiver_credit_fifo_if.sv
// ---------------------------------------------------------------------------
// receiver_credit_fifo_if
//   Bundles the link-side and consumer-side signals of the receiver credit
//   FIFO.
//
//   Signals
//     valid_i    : upstream link word valid (one word per asserted cycle)
//     data_i     : upstream link word
//     yummy_o    : one-cycle credit return pulse per freed entry
//     valid_o    : head entry available to the consumer
//     data_o     : head entry contents (show-ahead)
//     ready_i    : consumer accepts the head entry
//     count_o    : current occupancy, 0..DEPTH
//     overflow_o : sticky error, a word arrived with no free entry
//     rx_words_o : number of words accepted since reset (wraps)
//
//   Modports
//     slave  : the FIFO itself
//     master : the environment (upstream sender plus downstream consumer)
// ---------------------------------------------------------------------------
interface receiver_credit_fifo_if #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 64
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  valid_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  yummy_o;
   logic                  valid_o;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  ready_i;
   logic [CNT_W-1:0]      count_o;
   logic                  overflow_o;
   logic [31:0]           rx_words_o;

   modport slave (
      input  valid_i,
      input  data_i,
      input  ready_i,
      output yummy_o,
      output valid_o,
      output data_o,
      output count_o,
      output overflow_o,
      output rx_words_o
   );

   modport master (
      output valid_i,
      output data_i,
      output ready_i,
      input  yummy_o,
      input  valid_o,
      input  data_o,
      input  count_o,
      input  overflow_o,
      input  rx_words_o
   );
endinterface

// File: rtl/receiver_credit_fifo.sv
// ---------------------------------------------------------------------------
// receiver_credit_fifo
//   Receive side of a credit-based link. The upstream sender starts with
//   DEPTH credits and spends one per word; this block buffers the words in a
//   DEPTH-entry circular FIFO and hands a credit back (yummy_o) the cycle
//   after each entry is consumed. No credits are sent at reset: both ends
//   come out of reset agreeing that DEPTH entries are free.
//
//   Ports
//     clk_i  : single clock, all state changes on the rising edge
//     rstn_i : asynchronous active-low reset
//     bus    : receiver_credit_fifo_if.slave (see the interface for details)
//
//   Parameters
//     DEPTH      : FIFO entries / initial sender credits, power of two 2..16
//     DATA_WIDTH : link word width
// ---------------------------------------------------------------------------
module receiver_credit_fifo #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 64
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   receiver_credit_fifo_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_yummy;
   logic                  r_overflow;
   logic [31:0]           r_rx_words;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   logic                  w_not_empty;
   logic                  w_has_room;
   logic                  w_deq;
   logic                  w_enq;
   logic                  w_drop;
   logic [PTR_W-1:0]      w_wr_ptr_next;
   logic [PTR_W-1:0]      w_rd_ptr_next;
   logic [CNT_W-1:0]      w_count_next;

   assign w_not_empty = (r_count != '0);
   assign w_has_room  = (r_count < FULL_COUNT);

   // ready_i is meaningless while empty, so it is masked here rather than
   // letting it touch the read pointer, counter or credit path.
   assign w_deq = w_not_empty & bus.ready_i;

   // A full FIFO can still take a word when the head leaves in the same
   // cycle: the slot being freed is the one the write pointer lands on.
   assign w_enq  = bus.valid_i & (w_has_room | w_deq);
   assign w_drop = bus.valid_i & ~w_enq;

   // Explicit wrap so the pointers stay correct independent of how the
   // pointer width relates to DEPTH.
   assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
   assign w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);

   always_comb begin
      w_count_next = r_count;
      unique case ({w_enq, w_deq})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   // ------------------------------------------------------------------------
   // Storage: not reset, only ever read through the show-ahead port while
   // count is non-zero, so stale contents are never observable.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[r_wr_ptr] <= bus.data_i;
      end
   end

   // ------------------------------------------------------------------------
   // Pointers, occupancy and counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rx_words <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rx_words <= r_rx_words + 32'd1;
         end
         if (w_deq) begin
            r_rd_ptr <= w_rd_ptr_next;
         end
         r_count <= w_count_next;
      end
   end

   // ------------------------------------------------------------------------
   // Credit return and error flag
   // The credit pulse is simply the dequeue strobe delayed by one cycle, so
   // every consumed entry yields exactly one pulse and dropped words never
   // do. Reset clears a pulse that is about to be issued, which keeps the
   // sender's credit count in step with its own reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_yummy    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_yummy <= w_deq;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.valid_o    = w_not_empty;
   assign bus.data_o     = r_mem[r_rd_ptr];
   assign bus.count_o    = r_count;
   assign bus.yummy_o    = r_yummy;
   assign bus.overflow_o = r_overflow;
   assign bus.rx_words_o = r_rx_words;

endmodule
